// File: rtl/nic_pkg.sv
// rtl/nic_pkg.sv - shared types and helpers for the NIC router
package nic_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } nic_state_e;

   // Index width that stays legal (>=1 bit) for a single-entry vector.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/nic_rr_arbiter.sv
// rtl/nic_rr_arbiter.sv - round-robin arbiter, one-hot grant plus binary index
import nic_pkg::*;

module nic_rr_arbiter #(
   parameter int MASTERS_COUNT = 2,
   parameter int PW            = idx_width(MASTERS_COUNT)
) (
   input  logic [MASTERS_COUNT-1:0] i_req,
   input  logic [PW-1:0]            i_ptr,
   output logic [MASTERS_COUNT-1:0] o_gnt,
   output logic [PW-1:0]            o_idx
);

   int          cand;
   logic [PW-1:0] cand_idx;
   logic        found;

   // Scan from the pointer upward, wrapping, and take the first requester.
   always_comb begin
      o_gnt    = '0;
      o_idx    = '0;
      found    = 1'b0;
      cand     = 0;
      cand_idx = '0;
      for (int i = 0; i < MASTERS_COUNT; i++) begin
         cand = int'(i_ptr) + i;
         if (cand >= MASTERS_COUNT) begin
            cand = cand - MASTERS_COUNT;
         end
         cand_idx = PW'(cand);
         if (!found && i_req[cand_idx]) begin
            found           = 1'b1;
            o_gnt[cand_idx] = 1'b1;
            o_idx           = cand_idx;
         end
      end
   end

endmodule

// File: rtl/nic_router.sv
// rtl/nic_router.sv - multi-master to multi-slave request router with timeout
import nic_pkg::*;

module nic_router #(
   parameter int ADDR_SEL_WIDTH = 2,
   parameter int SLAVES_COUNT   = 4,
   parameter int MASTERS_COUNT  = 2,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                                          i_clk,
   input  logic                                          i_reset,
   input  logic [MASTERS_COUNT-1:0]                      i_req,
   input  logic [MASTERS_COUNT-1:0][ADDR_SEL_WIDTH-1:0]  i_addr_sel,
   output logic [MASTERS_COUNT-1:0]                      o_gnt,
   output logic [SLAVES_COUNT-1:0]                       o_slave_sel,
   input  logic [SLAVES_COUNT-1:0][DATA_WIDTH-1:0]       i_rdata,
   input  logic [SLAVES_COUNT-1:0]                       i_ack,
   output logic [DATA_WIDTH-1:0]                         o_rdata,
   output logic [MASTERS_COUNT-1:0]                      o_ack,
   output logic                                          o_err
);

   localparam int PW = idx_width(MASTERS_COUNT);
   localparam int CW = $clog2(TIMEOUT_CYCLES);

   nic_state_e              state_q, state_d;
   logic [PW-1:0]           rr_q, rr_d;
   logic [PW-1:0]           mst_q, mst_d;
   logic [ADDR_SEL_WIDTH-1:0] slv_q, slv_d;
   logic [CW-1:0]           cnt_q, cnt_d;
   logic                    err_q, err_d;
   logic [DATA_WIDTH-1:0]   data_q, data_d;

   logic [MASTERS_COUNT-1:0] arb_req;
   logic [MASTERS_COUNT-1:0] arb_gnt;
   logic [PW-1:0]            arb_idx;
   logic [ADDR_SEL_WIDTH-1:0] sel_addr;
   logic                    sel_ack;
   logic [DATA_WIDTH-1:0]   sel_rdata;

   // Arbitration only happens in IDLE and is gated off during reset.
   assign arb_req = (state_q == ST_IDLE && !i_reset) ? i_req : '0;

   nic_rr_arbiter #(
      .MASTERS_COUNT(MASTERS_COUNT),
      .PW           (PW)
   ) u_arb (
      .i_req(arb_req),
      .i_ptr(rr_q),
      .o_gnt(arb_gnt),
      .o_idx(arb_idx)
   );

   assign o_gnt    = arb_gnt;
   assign sel_addr = i_addr_sel[arb_idx];

   always_comb begin
      sel_ack   = 1'b0;
      sel_rdata = '0;
      for (int s = 0; s < SLAVES_COUNT; s++) begin
         if (int'(slv_q) == s) begin
            sel_ack   = i_ack[s];
            sel_rdata = i_rdata[s];
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      rr_d        = rr_q;
      mst_d       = mst_q;
      slv_d       = slv_q;
      cnt_d       = cnt_q;
      err_d       = err_q;
      data_d      = data_q;
      o_slave_sel = '0;
      o_ack       = '0;
      o_err       = 1'b0;
      o_rdata     = '0;
      unique case (state_q)
         ST_IDLE: begin
            if (|arb_gnt) begin
               mst_d = arb_idx;
               slv_d = sel_addr;
               rr_d  = (int'(arb_idx) == MASTERS_COUNT - 1) ? '0 : arb_idx + 1'b1;
               if (int'(sel_addr) < SLAVES_COUNT) begin
                  for (int s = 0; s < SLAVES_COUNT; s++) begin
                     o_slave_sel[s] = (int'(sel_addr) == s);
                  end
                  cnt_d   = '0;
                  state_d = ST_WAIT;
               end else begin
                  err_d   = 1'b1;
                  data_d  = '0;
                  state_d = ST_RESP;
               end
            end
         end
         ST_WAIT: begin
            if (sel_ack) begin
               err_d   = 1'b0;
               data_d  = sel_rdata;
               state_d = ST_RESP;
            end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
               err_d   = 1'b1;
               data_d  = '0;
               state_d = ST_RESP;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_RESP: begin
            for (int m = 0; m < MASTERS_COUNT; m++) begin
               o_ack[m] = (int'(mst_q) == m);
            end
            o_err   = err_q;
            o_rdata = data_q;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state_q <= ST_IDLE;
         rr_q    <= '0;
         mst_q   <= '0;
         slv_q   <= '0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         rr_q    <= rr_d;
         mst_q   <= mst_d;
         slv_q   <= slv_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
         data_q  <= data_d;
      end
   end

endmodule

// File: tb/tb_nic_router.sv
// tb/tb_nic_router.sv - directed self-checking bench for nic_router
module tb_nic_router;

   logic             clk;
   logic             rst;
   logic [1:0]       req;
   logic [1:0][1:0]  addr;
   logic [1:0]       gnt;
   logic [3:0]       ssel;
   logic [3:0][31:0] rdata;
   logic [3:0]       ack;
   logic [31:0]      ordata;
   logic [1:0]       oack;
   logic             oerr;

   logic [1:0]       req3;
   logic [1:0][1:0]  addr3;
   logic [1:0]       gnt3;
   logic [2:0]       ssel3;
   logic [2:0][31:0] rdata3;
   logic [2:0]       ack3;
   logic [31:0]      ordata3;
   logic [1:0]       oack3;
   logic             oerr3;

   int n_cmp;
   int n_bad;

   nic_router dut (
      .i_clk(clk), .i_reset(rst), .i_req(req), .i_addr_sel(addr), .o_gnt(gnt),
      .o_slave_sel(ssel), .i_rdata(rdata), .i_ack(ack), .o_rdata(ordata),
      .o_ack(oack), .o_err(oerr)
   );

   nic_router #(.SLAVES_COUNT(3)) dut3 (
      .i_clk(clk), .i_reset(rst), .i_req(req3), .i_addr_sel(addr3), .o_gnt(gnt3),
      .o_slave_sel(ssel3), .i_rdata(rdata3), .i_ack(ack3), .o_rdata(ordata3),
      .o_ack(oack3), .o_err(oerr3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; req = 2'b11; addr[0] = 2'd0; addr[1] = 2'd1; #1;
      n_cmp++; if (gnt !== 2'b00) begin $display("FAIL reset_gnt: got %b want 00", gnt); n_bad++; end
      n_cmp++; if (ssel !== 4'b0000) begin $display("FAIL reset_sel: got %b want 0000", ssel); n_bad++; end
      step();
      n_cmp++; if ({oack, oerr, ordata} !== 35'd0) begin $display("FAIL reset_resp: got %h want 0", {oack, oerr, ordata}); n_bad++; end
      req = 2'b00;
      rst = 1'b0;
   endtask

   task automatic test_basic();
      req = 2'b01; addr[0] = 2'd2; #1;
      n_cmp++; if (gnt !== 2'b01) begin $display("FAIL basic_gnt: got %b want 01", gnt); n_bad++; end
      n_cmp++; if (ssel !== 4'b0100) begin $display("FAIL basic_sel: got %b want 0100", ssel); n_bad++; end
      step();
      req = 2'b00; ack = 4'b0100; rdata[2] = 32'hDEADBEEF; #1;
      n_cmp++; if ({ssel, oack} !== 6'd0) begin $display("FAIL basic_wait: got %b want 0", {ssel, oack}); n_bad++; end
      step();
      ack = 4'b0000;
      n_cmp++; if (oack !== 2'b01) begin $display("FAIL basic_ack: got %b want 01", oack); n_bad++; end
      n_cmp++; if (ordata !== 32'hDEADBEEF) begin $display("FAIL basic_rdata: got %h want deadbeef", ordata); n_bad++; end
      n_cmp++; if (oerr !== 1'b0) begin $display("FAIL basic_err: got %b want 0", oerr); n_bad++; end
      step();
      n_cmp++; if ({oack, ordata} !== 34'd0) begin $display("FAIL basic_idle: got %h want 0", {oack, ordata}); n_bad++; end
   endtask

   task automatic test_round_robin();
      logic [1:0] exp_g;
      logic [31:0] exp_d;
      do_reset();
      rdata[1] = 32'h1111_0001; rdata[3] = 32'h3333_0003;
      addr[0] = 2'd1; addr[1] = 2'd3; ack = 4'b1111; req = 2'b11;
      for (int n = 0; n < 4; n++) begin
         exp_g = (n % 2 == 1) ? 2'b10 : 2'b01;
         exp_d = (n % 2 == 1) ? 32'h3333_0003 : 32'h1111_0001;
         #1;
         n_cmp++; if (gnt !== exp_g) begin $display("FAIL rr_gnt%0d: got %b want %b", n, gnt, exp_g); n_bad++; end
         step();
         n_cmp++; if (gnt !== 2'b00) begin $display("FAIL rr_wait_gnt%0d: got %b want 00", n, gnt); n_bad++; end
         step();
         n_cmp++; if (gnt !== 2'b00 || oack !== exp_g) begin $display("FAIL rr_resp%0d: got gnt %b ack %b want gnt 00 ack %b", n, gnt, oack, exp_g); n_bad++; end
         n_cmp++; if (ordata !== exp_d) begin $display("FAIL rr_rdata%0d: got %h want %h", n, ordata, exp_d); n_bad++; end
         step();
      end
      req = 2'b00; ack = 4'b0000;
   endtask

   task automatic test_decode_err();
      req3 = 2'b10; addr3[1] = 2'd3; rdata3[0] = 32'hFFFF_FFFF; #1;
      n_cmp++; if (gnt3 !== 2'b10) begin $display("FAIL dec_gnt: got %b want 10", gnt3); n_bad++; end
      n_cmp++; if (ssel3 !== 3'b000) begin $display("FAIL dec_sel: got %b want 000", ssel3); n_bad++; end
      step();
      req3 = 2'b00;
      n_cmp++; if (oack3 !== 2'b10 || oerr3 !== 1'b1) begin $display("FAIL dec_resp: got ack %b err %b want 10 1", oack3, oerr3); n_bad++; end
      n_cmp++; if (ordata3 !== 32'd0) begin $display("FAIL dec_rdata: got %h want 0", ordata3); n_bad++; end
      step();
      n_cmp++; if (oack3 !== 2'b00) begin $display("FAIL dec_idle: got %b want 00", oack3); n_bad++; end
   endtask

   task automatic test_timeout();
      int first;
      first = 0;
      req = 2'b01; addr[0] = 2'd1; rdata[1] = 32'hCAFE_0001; #1;
      n_cmp++; if (gnt !== 2'b01) begin $display("FAIL to_gnt: got %b want 01", gnt); n_bad++; end
      for (int k = 1; k <= 20 && first == 0; k++) begin
         step();
         req = 2'b00;
         if (oack !== 2'b00) first = k;
      end
      n_cmp++; if (first != 17) begin $display("FAIL to_latency: got cycle %0d want 17", first); n_bad++; end
      n_cmp++; if (oerr !== 1'b1 || ordata !== 32'd0) begin $display("FAIL to_resp: got err %b data %h want 1 0", oerr, ordata); n_bad++; end
      step();
      ack = 4'b0010; #1;
      n_cmp++; if (oack !== 2'b00 || gnt !== 2'b00) begin $display("FAIL to_late_ack: got ack %b gnt %b want 00 00", oack, gnt); n_bad++; end
      step();
      ack = 4'b0000;
      n_cmp++; if (oack !== 2'b00) begin $display("FAIL to_late_ack2: got %b want 00", oack); n_bad++; end
      req = 2'b01; rdata[1] = 32'h0000_1234; #1;
      n_cmp++; if (gnt !== 2'b01) begin $display("FAIL to_next_gnt: got %b want 01", gnt); n_bad++; end
      step();
      req = 2'b00; ack = 4'b0010;
      step();
      ack = 4'b0000;
      n_cmp++; if (oack !== 2'b01 || oerr !== 1'b0 || ordata !== 32'h0000_1234) begin $display("FAIL to_next_resp: got ack %b err %b data %h want 01 0 00001234", oack, oerr, ordata); n_bad++; end
      step();
   endtask

   task automatic test_reset_mid();
      int acks;
      acks = 0;
      req = 2'b01; addr[0] = 2'd0; addr[1] = 2'd2; #1;
      n_cmp++; if (gnt !== 2'b01) begin $display("FAIL rm_gnt: got %b want 01", gnt); n_bad++; end
      step();
      req = 2'b10; rst = 1'b1; #1;
      n_cmp++; if ({gnt, ssel, oack, oerr, ordata} !== 41'd0) begin $display("FAIL rm_outputs: got %h want 0", {gnt, ssel, oack, oerr, ordata}); n_bad++; end
      for (int k = 0; k < 3; k++) begin
         step();
         if (oack !== 2'b00) acks++;
      end
      n_cmp++; if (acks != 0) begin $display("FAIL rm_no_ack: got %0d acks want 0", acks); n_bad++; end
      rst = 1'b0; #1;
      n_cmp++; if (gnt !== 2'b10) begin $display("FAIL rm_post_gnt: got %b want 10", gnt); n_bad++; end
      n_cmp++; if (ssel !== 4'b0100) begin $display("FAIL rm_post_sel: got %b want 0100", ssel); n_bad++; end
      step();
      req = 2'b00; ack = 4'b0100; rdata[2] = 32'h0BAD_F00D;
      step();
      ack = 4'b0000;
      n_cmp++; if (oack !== 2'b10 || ordata !== 32'h0BAD_F00D) begin $display("FAIL rm_post_resp: got ack %b data %h want 10 0badf00d", oack, ordata); n_bad++; end
      step();
   endtask

   task automatic test_ignore_other();
      req = 2'b01; addr[0] = 2'd1; #1;
      n_cmp++; if (ssel !== 4'b0010) begin $display("FAIL io_sel: got %b want 0010", ssel); n_bad++; end
      step();
      req = 2'b00; ack = 4'b0001; rdata[0] = 32'hBAAD_0000; rdata[1] = 32'h600D_0001;
      step();
      n_cmp++; if (oack !== 2'b00) begin $display("FAIL io_ignored: got %b want 00", oack); n_bad++; end
      ack = 4'b0010;
      step();
      ack = 4'b0000;
      n_cmp++; if (oack !== 2'b01 || ordata !== 32'h600D_0001) begin $display("FAIL io_resp: got ack %b data %h want 01 600d0001", oack, ordata); n_bad++; end
      step();
   endtask

   initial begin
      n_cmp = 0; n_bad = 0;
      rst = 1'b1; req = '0; addr = '0; ack = '0; rdata = '0;
      req3 = '0; addr3 = '0; ack3 = '0; rdata3 = '0;
      step();
      test_reset();
      step();
      test_basic();
      test_round_robin();
      test_decode_err();
      test_timeout();
      test_reset_mid();
      test_ignore_other();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
